// File: rtl/pe_array_engine.sv
// Broadcast-weight PE array: each PE accumulates sum(data[lane] * weight) over a group of
// beats, then saturates the total into a held result with a valid/ready output handshake.
module pe_array_engine #(
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 4,
  parameter int RESULT_WIDTH = 16,
  parameter int PE_NUM       = 4,
  parameter int LANES        = 4,
  parameter int ACC_LEN      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic                               weight_signed,
  input  logic [WEIGHT_WIDTH-1:0]            common_weight_in,
  input  logic [PE_NUM*LANES*DATA_WIDTH-1:0] data_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [PE_NUM*RESULT_WIDTH-1:0]     result_out
);

  localparam int ACC_MIN_W = DATA_WIDTH + WEIGHT_WIDTH + 1 + $clog2(LANES) + $clog2(ACC_LEN);
  localparam int ACC_W     = (ACC_MIN_W > RESULT_WIDTH) ? ACC_MIN_W : RESULT_WIDTH;
  localparam int CNT_W     = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

  localparam logic signed [ACC_W-1:0] RES_MAX =
    {{(ACC_W-RESULT_WIDTH+1){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN =
    {{(ACC_W-RESULT_WIDTH+1){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     grp_signed_q;
  logic                     grp_signed;
  logic                     accept;
  logic                     close;
  logic signed [WEIGHT_WIDTH:0] w_ext;
  logic signed [ACC_W-1:0]  acc     [PE_NUM];
  logic signed [ACC_W-1:0]  acc_sum [PE_NUM];
  logic [PE_NUM*RESULT_WIDTH-1:0] sat_vec;

  // Output decode
  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = !out_valid || out_ready;
  end

  assign accept = in_valid && in_ready;
  assign close  = accept && (in_last || (beat_cnt == CNT_W'(ACC_LEN - 1)));

  // The first beat of a group uses the live mode bit; later beats use the latched one.
  assign grp_signed = (beat_cnt == '0) ? weight_signed : grp_signed_q;
  assign w_ext      = {grp_signed & common_weight_in[WEIGHT_WIDTH-1], common_weight_in};

  always_comb begin
    logic signed [DATA_WIDTH-1:0] lane;
    lane    = '0;
    sat_vec = '0;
    for (int unsigned p = 0; p < PE_NUM; p++) begin
      acc_sum[p] = acc[p];
      for (int unsigned l = 0; l < LANES; l++) begin
        lane       = data_in[(p*LANES + l)*DATA_WIDTH +: DATA_WIDTH];
        acc_sum[p] = acc_sum[p] + ACC_W'(lane) * ACC_W'(w_ext);
      end
      if (acc_sum[p] > RES_MAX)
        sat_vec[p*RESULT_WIDTH +: RESULT_WIDTH] = RES_MAX[RESULT_WIDTH-1:0];
      else if (acc_sum[p] < RES_MIN)
        sat_vec[p*RESULT_WIDTH +: RESULT_WIDTH] = RES_MIN[RESULT_WIDTH-1:0];
      else
        sat_vec[p*RESULT_WIDTH +: RESULT_WIDTH] = acc_sum[p][RESULT_WIDTH-1:0];
    end
  end

  // A closing beat in HOLD with out_ready replaces the consumed result, so stay in HOLD.
  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (close) state_next = HOLD;
      HOLD:  if (out_ready) state_next = close ? HOLD : ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      beat_cnt     <= '0;
      grp_signed_q <= 1'b0;
      result_out   <= '0;
      for (int unsigned p = 0; p < PE_NUM; p++) acc[p] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (beat_cnt == '0) grp_signed_q <= weight_signed;
        if (close) begin
          beat_cnt   <= '0;
          result_out <= sat_vec;
          for (int unsigned p = 0; p < PE_NUM; p++) acc[p] <= '0;
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          for (int unsigned p = 0; p < PE_NUM; p++) acc[p] <= acc_sum[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_array_engine.sv
// Scoreboard bench for pe_array_engine: a longint reference model pushes expected result
// vectors as beats are accepted; a negedge monitor pops and compares on each handshake.
module tb_pe_array_engine;

  localparam int DW = 16, WW = 4, RW = 16, PN = 4, LN = 4, AL = 4;

  logic               clk = 0;
  logic               rst = 1;
  logic               in_valid = 0;
  logic               in_ready;
  logic               in_last = 0;
  logic               weight_signed = 0;
  logic [WW-1:0]      common_weight_in = '0;
  logic [PN*LN*DW-1:0] data_in = '0;
  logic               out_valid;
  logic               out_ready = 0;
  logic [PN*RW-1:0]   result_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [PN*RW-1:0] exp_q[$];
  longint m_acc[PN];
  int     m_cnt = 0;
  bit     m_gs = 0;

  pe_array_engine #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .RESULT_WIDTH(RW),
    .PE_NUM(PN), .LANES(LN), .ACC_LEN(AL)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .weight_signed(weight_signed), .common_weight_in(common_weight_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got=running required=finished");
    $fatal(1, "watchdog");
  end

  // Inputs change only #1 after posedge, so negedge sees what the next posedge will use.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_result got=%h required=no result", result_out);
      end else begin
        logic [PN*RW-1:0] e;
        e = exp_q.pop_front();
        if (result_out !== e)
          $display("FAIL result got=%h required=%h", result_out, e);
        else
          pass_cnt++;
      end
    end
  end

  function automatic logic [PN*LN*DW-1:0] fill(input logic [DW-1:0] v);
    logic [PN*LN*DW-1:0] r;
    for (int i = 0; i < PN*LN; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [PN*RW-1:0] model_sat();
    logic [PN*RW-1:0] r;
    for (int p = 0; p < PN; p++) begin
      if (m_acc[p] > 32767)       r[p*RW +: RW] = 16'h7FFF;
      else if (m_acc[p] < -32768) r[p*RW +: RW] = 16'h8000;
      else                        r[p*RW +: RW] = m_acc[p][15:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < PN; p++) m_acc[p] = 0;
    m_cnt = 0;
  endtask

  task automatic model_beat(input logic [PN*LN*DW-1:0] d, input logic [WW-1:0] w,
                            input bit ws, input bit last);
    longint wv;
    logic signed [DW-1:0] dv;
    if (m_cnt == 0) m_gs = ws;
    wv = m_gs ? longint'($signed(w)) : longint'(w);
    for (int p = 0; p < PN; p++)
      for (int l = 0; l < LN; l++) begin
        dv = d[(p*LN + l)*DW +: DW];
        m_acc[p] += longint'(dv) * wv;
      end
    if (last || m_cnt == AL-1) begin
      exp_q.push_back(model_sat());
      model_clear();
    end else begin
      m_cnt++;
    end
  endtask

  // Presents one beat until accepted; after force_after misses, out_ready is raised.
  task automatic send_beat(input logic [PN*LN*DW-1:0] d, input logic [WW-1:0] w,
                           input bit ws, input bit last, input int force_after,
                           output int waited);
    bit done = 0;
    in_valid = 1; data_in = d; common_weight_in = w; weight_signed = ws; in_last = last;
    waited = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        model_beat(d, w, ws, last);
        done = 1;
      end else begin
        waited++;
        if (waited >= 50) begin
          total_cnt++;
          $display("FAIL accept_timeout got=in_ready low required=beat accepted");
          done = 1;
        end else begin
          @(posedge clk); #1;
          if (waited >= force_after) out_ready = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (exp_q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL drain got=pending=%0d out_valid=%b required=pending=0 out_valid=0",
               exp_q.size(), out_valid);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b required=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (result_out !== '0) $display("FAIL reset_result got=%h required=0", result_out);
    else pass_cnt++;
    rst = 0;
    @(posedge clk); #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", in_ready);
    else pass_cnt++;
    model_clear();
  endtask

  task automatic test_unsigned();
    int wt;
    out_ready = 1;
    for (int b = 0; b < 3; b++) send_beat(fill(16'd1), 4'h2, 0, 0, 50, wt);
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL unsigned_early_valid got=%b required=0", out_valid);
    else pass_cnt++;
    send_beat(fill(16'd1), 4'h2, 0, 0, 50, wt);
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL unsigned_latency got=%b required=1", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (result_out !== {PN{16'd32}})
      $display("FAIL unsigned_value got=%h required=%h", result_out, {PN{16'd32}});
    else pass_cnt++;
    drain();
  endtask

  task automatic test_signed_last();
    logic [PN*LN*DW-1:0] d;
    int wt;
    for (int i = 0; i < PN*LN; i++) d[i*DW +: DW] = DW'(i % LN + 1);
    send_beat(d, 4'hF, 1, 1, 50, wt);
    total_cnt++;
    if (result_out !== {PN{16'hFFF6}})
      $display("FAIL signed_last got=%h required=%h", result_out, {PN{16'hFFF6}});
    else pass_cnt++;
    drain();
  endtask

  task automatic test_saturation();
    int wt;
    for (int b = 0; b < 4; b++) send_beat(fill(16'h7FFF), 4'h7, 0, 0, 50, wt);
    drain();
    for (int b = 0; b < 4; b++) send_beat(fill(16'h8000), 4'h7, 0, 0, 50, wt);
    total_cnt++;
    if (result_out !== {PN{16'h8000}})
      $display("FAIL sat_neg got=%h required=%h", result_out, {PN{16'h8000}});
    else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    int wt;
    out_ready = 0;
    send_beat(fill(16'd3), 4'h1, 0, 1, 50, wt);
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_handshake got=out_valid=%b in_ready=%b required=1/0", out_valid, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (result_out !== {PN{16'd12}})
        $display("FAIL bp_stable got=%h required=%h", result_out, {PN{16'd12}});
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1;
    send_beat(fill(16'd1), 4'h1, 0, 1, 50, wt);
    total_cnt++;
    if (wt !== 0) $display("FAIL bp_zero_bubble got=waited %0d required=0", wt);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL bp_reload_valid got=%b required=1", out_valid);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    int wt;
    out_ready = 1;
    send_beat(fill(16'd1), 4'h1, 0, 0, 50, wt);
    send_beat(fill(16'd1), 4'h1, 0, 0, 50, wt);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    total_cnt++;
    if (out_valid !== 1'b0 || result_out !== '0)
      $display("FAIL rst_mid_state got=out_valid=%b result=%h required=0/0", out_valid, result_out);
    else pass_cnt++;
    send_beat(fill(16'd1), 4'h1, 0, 1, 50, wt);
    total_cnt++;
    if (result_out !== {PN{16'd4}})
      $display("FAIL rst_mid_value got=%h required=%h", result_out, {PN{16'd4}});
    else pass_cnt++;
    drain();
  endtask

  task automatic test_mode_change();
    int wt;
    send_beat(fill(16'd1), 4'h2, 1, 0, 50, wt);
    send_beat(fill(16'd1), 4'hF, 0, 1, 50, wt);
    total_cnt++;
    if (result_out !== {PN{16'd4}})
      $display("FAIL mode_change got=%h required=%h", result_out, {PN{16'd4}});
    else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [PN*LN*DW-1:0] d;
    int wt;
    for (int b = 0; b < 40; b++) begin
      bit big;
      big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < PN*LN; i++)
        d[i*DW +: DW] = big ? DW'($urandom) : DW'($signed(8'($urandom)));
      out_ready = 1'($urandom_range(0, 1));
      send_beat(d, WW'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), 2, wt);
    end
    drain();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_unsigned();
    test_signed_last();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_mode_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pe_array_engine.md
PE_ARRAY_ENGINE -- requirements
Module: pe_array_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each data lane, two's complement signed.
REQ-002 Parameter WEIGHT_WIDTH, default 4: width of the common broadcast weight.
REQ-003 Parameter RESULT_WIDTH, default 16: width of each PE result, signed.
REQ-004 Parameter PE_NUM, default 4: number of processing elements.
REQ-005 Parameter LANES, default 4: data lanes per PE.
REQ-006 Parameter ACC_LEN, default 4: maximum beats accumulated per result group, >=1.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  input beat valid.
REQ-010 in_ready  output  1  engine can accept a beat.
REQ-011 in_last  input  1  final beat of the current group.
REQ-012 weight_signed  input  1  1 = weight is signed, 0 = weight is unsigned.
REQ-013 common_weight_in  input  WEIGHT_WIDTH  weight broadcast to all PEs and lanes.
REQ-014 data_in  input  PE_NUM*LANES*DATA_WIDTH  packed [PE_NUM][LANES][DATA_WIDTH] data.
REQ-015 out_valid  output  1  result_out holds a completed group.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 result_out  output  PE_NUM*RESULT_WIDTH  packed [PE_NUM][RESULT_WIDTH] results.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-019 For each accepted beat, PE p SHALL add sum over l of data_in[p][l]*weight to its accumulator; the weight is sign- or zero-extended per the group's weight_signed.
REQ-020 weight_signed SHALL be sampled on the first beat of a group and held for the whole group; changes mid-group are ignored.
REQ-021 Accumulators SHALL be at least DATA_WIDTH+WEIGHT_WIDTH+1+clog2(LANES)+clog2(ACC_LEN) bits wide and SHALL never wrap internally.
REQ-022 A beat counter SHALL count accepted beats in the group (0..ACC_LEN-1); a group SHALL close on an accepted beat with in_last=1 or on the ACC_LEN-th accepted beat, whichever comes first.
REQ-023 On group close, result_out[p] SHALL be loaded with the accumulator saturated to signed RESULT_WIDTH range (clip to max/min); out_valid SHALL rise the next cycle (one-cycle latency from the closing beat).
REQ-024 FSM states: ACCUM (collecting beats) and HOLD (result pending); ACCUM->HOLD on group close; HOLD->ACCUM on out_valid && out_ready.
REQ-025 in_ready SHALL equal !out_valid || out_ready.
REQ-026 When out_valid && out_ready && in_valid coincide, the result SHALL be consumed and the beat SHALL be accepted as the first beat of a new group in the same cycle (zero bubble).
REQ-027 A beat closing a group in the same cycle the prior result is consumed SHALL load the new result, and out_valid SHALL remain 1.
REQ-028 result_out SHALL remain stable while out_valid && !out_ready.
REQ-029 After a group closes, accumulators and beat counter SHALL restart from zero for the next group.

Reset
REQ-030 On rst=1 at a rising edge: out_valid=0, result_out=0, accumulators=0, beat counter=0, FSM=ACCUM; in_ready=1 the following cycle.
REQ-031 Reset mid-group SHALL discard the partial accumulation; no result SHALL be emitted for that group.

Verification (PE_NUM=4, LANES=4, DATA_WIDTH=16, WEIGHT_WIDTH=4, RESULT_WIDTH=16, ACC_LEN=4)
REQ-032 Unsigned: weight=4'h2, weight_signed=0, all data=1, 4 beats, in_last=0 -> out_valid 1 cycle after 4th beat, every result=32.
REQ-033 Signed/early last: weight=4'hF, weight_signed=1, lanes {1,2,3,4} on every PE, one beat with in_last=1 -> every result=-10 (16'hFFF6).
REQ-034 Saturation: all data=16'h7FFF, weight=4'h7 unsigned, 4 beats -> every result=16'h7FFF; all data=16'h8000, same weight -> 16'h8000.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles after out_valid -> in_ready=0 and result_out unchanged; then out_ready=1 with in_valid=1 -> result consumed and beat accepted in the same cycle.
REQ-036 Reset mid-group: 2 beats with weight=1, data=1, then rst for one cycle, then 1 beat with in_last=1 -> result=4, not 12.
REQ-037 Mode change mid-group: first beat weight_signed=1, second beat weight_signed=0 with weight=4'hF -> second beat uses -1.
